div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/math_pkg.sv | 23 ++
 rtl/div.sv | 190 +++++++++++++++++++
 tb/tb_div.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/math_pkg.sv
// ============================================================================
// math_pkg -- shared Q-format constants for the fixed-point div/mul blocks
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

package math_pkg;

  localparam int Q_WIDTH = 25;
  localparam int Q_FBITS = 21;

  localparam logic signed [Q_WIDTH-1:0] Q_ONE = Q_WIDTH'(1) << Q_FBITS;
  localparam logic signed [Q_WIDTH-1:0] Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic signed [Q_WIDTH-1:0] Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

  localparam logic [1:0] DIV_S_IDLE  = 2'd0;
  localparam logic [1:0] DIV_S_INIT  = 2'd1;
  localparam logic [1:0] DIV_S_CALC  = 2'd2;
  localparam logic [1:0] DIV_S_ROUND = 2'd3;

endpackage

`default_nettype wire

// File: rtl/div.sv
// ============================================================================
// div -- signed fixed-point restoring divider, one quotient bit per cycle.
// Build macro DIV_ROUND_EN: round half-to-even instead of truncating.
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module div
  import math_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FBITS = Q_FBITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic                    ovf,
  output logic                    dbz,
  output logic signed [WIDTH-1:0] val
);

  localparam int ITER = WIDTH + FBITS + 1;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0]   LAST    = CW'(ITER - 1);
  localparam logic [ITER-1:0] POS_LIM = {{(FBITS+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [ITER-1:0] NEG_LIM = POS_LIM + ITER'(1);

  logic [1:0]              state_q, state_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                    sign_q, sign_d;
  logic [WIDTH-1:0]        bmag_q, bmag_d;
  logic [ITER-1:0]         num_q, num_d;
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dbzp_q, dbzp_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    valid_q, valid_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic signed [WIDTH-1:0] val_q, val_d;

  logic [WIDTH-1:0] w_amag, w_bmag, w_diff, w_low;
  logic [WIDTH:0]   w_shift;
  logic             w_ge, w_ovf;
  logic [ITER-1:0]  w_mag;

  // Negating MIN wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
  assign w_amag  = a_q[WIDTH-1] ? -a_q : a_q;
  assign w_bmag  = b_q[WIDTH-1] ? -b_q : b_q;
  assign w_shift = {rem_q, num_q[ITER-1]};
  assign w_ge    = w_shift >= {1'b0, bmag_q};
  assign w_diff  = w_shift[WIDTH-1:0] - bmag_q;

`ifdef DIV_ROUND_EN
  logic w_inc;
  assign w_inc = num_q[0] & ((rem_q != '0) | num_q[1]);
  assign w_mag = {1'b0, num_q[ITER-1:1]} + ITER'(w_inc);
`else
  assign w_mag = {1'b0, num_q[ITER-1:1]};
`endif

  assign w_ovf = w_mag > (sign_q ? NEG_LIM : POS_LIM);
  assign w_low = w_mag[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_S_IDLE;
    else     state_q <= state_d;
  end

  // A start seen while done is high is dropped so back-to-back pulses need a gap
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_S_IDLE:  if (start && !done_q) state_d = DIV_S_INIT;
      DIV_S_INIT:  state_d = (b_q == '0) ? DIV_S_ROUND : DIV_S_CALC;
      DIV_S_CALC:  if (cnt_q == LAST) state_d = DIV_S_ROUND;
      DIV_S_ROUND: state_d = DIV_S_IDLE;
      default:     state_d = DIV_S_IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    bmag_d  = bmag_q;
    num_d   = num_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbzp_d  = dbzp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    val_d   = val_q;
    case (state_q)
      DIV_S_IDLE: begin
        if (start && !done_q) begin
          a_d     = a;
          b_d     = b;
          sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
          busy_d  = 1'b1;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          val_d   = '0;
        end
      end
      DIV_S_INIT: begin
        bmag_d = w_bmag;
        num_d  = {w_amag, {(FBITS+1){1'b0}}};
        rem_d  = '0;
        cnt_d  = '0;
        dbzp_d = (b_q == '0);
      end
      DIV_S_CALC: begin
        // Dividend bits shift out the top while quotient bits shift in at the bottom
        num_d = {num_q[ITER-2:0], w_ge};
        rem_d = w_ge ? w_diff : w_shift[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
      end
      DIV_S_ROUND: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (dbzp_q) begin
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
          val_d   = '0;
        end else if (w_ovf) begin
          ovf_d   = 1'b1;
          valid_d = 1'b0;
          val_d   = '0;
        end else begin
          valid_d = 1'b1;
          val_d   = sign_q ? -w_low : w_low;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      bmag_q  <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbzp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      val_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      bmag_q  <= bmag_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbzp_q  <= dbzp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      val_q   <= val_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign dbz   = dbz_q;
  assign val   = val_q;

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ============================================================================
// tb_div -- randomized and directed checks of div against an arithmetic model.
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_div;

  logic               clk = 1'b0;
  logic               rst, start;
  logic signed [24:0] a, b;
  logic               busy, done, valid, ovf, dbz;
  logic signed [24:0] val;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  div dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .valid(valid), .ovf(ovf), .dbz(dbz), .val(val)
  );

  always #5 clk = ~clk;

  // Exact quotient from integer arithmetic: Q = floor(|a|*2^22/|b|), M = Q/2
  function automatic void calc(input logic signed [24:0] x, input logic signed [24:0] y,
                               output logic [24:0] v, output bit vl, output bit ov, output bit z);
    longint sx, sy, q, r, m;
    bit neg;
    v = '0; vl = 1'b0; ov = 1'b0; z = 1'b0;
    sx = longint'(x);
    sy = longint'(y);
    neg = (sx < 0) != (sy < 0);
    if (sy == 0) begin
      z = 1'b1;
      return;
    end
    if (sx < 0) sx = -sx;
    if (sy < 0) sy = -sy;
    q = (sx * 64'sd4194304) / sy;
    r = (sx * 64'sd4194304) % sy;
    m = q / 2;
`ifdef DIV_ROUND_EN
    if ((q % 2 == 1) && (r != 0 || m % 2 == 1)) m = m + 1;
`endif
    if (m > (neg ? 64'sd16777216 : 64'sd16777215)) ov = 1'b1;
    else begin
      vl = 1'b1;
      v  = neg ? 25'(-m) : 25'(m);
    end
  endfunction

  // Transaction-level timeline model
  bit          mb, md, mv, mo, mz, was_done;
  logic [24:0] mval;
  logic [24:0] pv;
  bit          pvl, po, pz;
  int          left = 0;

  always @(posedge clk) begin
    was_done = md;
    if (rst) begin
      mb = 0; md = 0; mv = 0; mo = 0; mz = 0; mval = '0; left = 0;
    end else begin
      md = 0;
      if (left > 0) begin
        left = left - 1;
        if (left == 0) begin
          mb = 0; md = 1; mval = pv; mv = pvl; mo = po; mz = pz;
        end
      end else if (start && !was_done) begin
        calc(a, b, pv, pvl, po, pz);
        mb = 1; mv = 0; mo = 0; mz = 0; mval = '0;
        left = pz ? 2 : 49;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if ({busy, done, valid, ovf, dbz, val} !== {mb, md, mv, mo, mz, mval}) begin
        miscompares++;
        $display("FAIL cycle t=%0t busy/done/valid/ovf/dbz/val got %b/%b/%b/%b/%b/%h required %b/%b/%b/%b/%b/%h",
                 $time, busy, done, valid, ovf, dbz, val, mb, md, mv, mo, mz, mval);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic op(input string nm, input logic signed [24:0] ta, input logic signed [24:0] tbv,
                    input logic signed [24:0] ev, input bit evl, input bit eo, input bit ez,
                    input int elat);
    int n, bc;
    a = ta; b = tbv; start = 1'b1;
    tick();
    start = 1'b0; a = 25'($urandom); b = 25'($urandom);
    n = 1; bc = 0;
    while (!done && n <= 200) begin
      if (busy) bc++;
      tick();
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(elat));
    chk({nm, " busy cycles"}, 32'(bc), 32'(elat - 1));
    chk({nm, " val"}, {7'b0, val}, {7'b0, ev});
    chk({nm, " valid/ovf/dbz"}, {29'b0, valid, ovf, dbz}, {29'b0, evl, eo, ez});
    tick();
    tick();
  endtask

  initial begin
    int n, dc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    chk("reset outputs", {25'b0, busy, done, valid, ovf, dbz, 2'b0}, 32'h0);
    chk("reset val", {7'b0, val}, 32'h0);
    checking = 1'b1;
    rst = 1'b0;
    tick();

    op("3/2",       25'sh0600000, 25'sh0400000, 25'sh0300000, 1, 0, 0, 50);
`ifdef DIV_ROUND_EN
    op("1/3",       25'sh0200000, 25'sh0600000, 25'sh00AAAAB, 1, 0, 0, 50);
    op("-1/3",     -25'sh0200000, 25'sh0600000, -25'sh00AAAAB, 1, 0, 0, 50);
    op("tie even",  25'sh0000001, 25'sh0400000, 25'sh0000000, 1, 0, 0, 50);
    op("tie odd",   25'sh0000003, 25'sh0400000, 25'sh0000002, 1, 0, 0, 50);
`else
    op("1/3",       25'sh0200000, 25'sh0600000, 25'sh00AAAAA, 1, 0, 0, 50);
    op("-1/3",     -25'sh0200000, 25'sh0600000, -25'sh00AAAAA, 1, 0, 0, 50);
    op("tie even",  25'sh0000001, 25'sh0400000, 25'sh0000000, 1, 0, 0, 50);
    op("tie odd",   25'sh0000003, 25'sh0400000, 25'sh0000001, 1, 0, 0, 50);
`endif
    op("4/0.25 ovf", 25'sh0800000, 25'sh0080000, 25'sh0000000, 0, 1, 0, 50);
    op("MIN/1",     25'sh1000000, 25'sh0200000, 25'sh1000000, 1, 0, 0, 50);
    op("MIN/-1 ovf", 25'sh1000000, 25'sh1E00000, 25'sh0000000, 0, 1, 0, 50);
    op("x/0 dbz",   25'sh0123456, 25'sh0000000, 25'sh0000000, 0, 0, 1, 3);

    // Abort 10 cycles in; rst also wins over a coincident start
    a = 25'sh0600000; b = 25'sh0400000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("abort outputs", {25'b0, busy, done, valid, ovf, dbz, 2'b0}, 32'h0);
    chk("abort val", {7'b0, val}, 32'h0);
    dc = 0;
    repeat (60) begin
      if (done) dc++;
      tick();
    end
    chk("abort done count", 32'(dc), 32'd0);

    // Second start while busy is dropped
    a = 25'sh0600000; b = 25'sh0400000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    a = 25'sh0200000; b = 25'sh0600000; start = 1'b1;
    tick();
    start = 1'b0;
    dc = 0; n = 0;
    while (n < 80) begin
      if (done) begin
        dc++;
        if (dc == 1) chk("busy-ignore val", {7'b0, val}, 32'h0300000);
      end
      tick();
      n++;
    end
    chk("busy-ignore done count", 32'(dc), 32'd1);

    // Start during the done cycle is dropped, the following cycle is taken
    a = 25'sh0600000; b = 25'sh0000000; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("done seen", 32'(done), 32'd1);
    a = 25'sh0200000; b = 25'sh0400000; start = 1'b1;
    tick();
    chk("start on done ignored", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    chk("start after done taken", 32'(busy), 32'd1);
    repeat (60) tick();

    // Randomized traffic against the timeline model
    for (int i = 0; i < 5000; i++) begin
      int sel;
      rst   = ($urandom_range(0, 599) == 0);
      start = done ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 15);
      a = (sel == 0) ? 25'sh1000000 : (sel == 1) ? 25'sh0FFFFFF : 25'($urandom);
      sel = $urandom_range(0, 15);
      b = (sel == 0) ? 25'sh0000000 : (sel < 4) ? 25'($signed(10'($urandom))) : 25'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
